// File: rtl/prog_counter.sv
// Programmable prescaled counter: up-wrap, down-wrap, bounce and one-shot modes,
// with parallel load and a registered terminal-count pulse.
module prog_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV_W = 8
) (
    input  logic             gclk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             busy_o,
    output logic             dir_o
);

    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        OS_IDLE = 2'b00,
        OS_RUN  = 2'b01,
        OS_DONE = 2'b10
    } os_state_e;

    logic [DIV_W-1:0] pre_q,   pre_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q,    tc_d;
    logic             dir_q,   dir_d;
    logic             busy_q,  busy_d;
    os_state_e        os_q,    os_d;

    mode_e            mode;
    logic             tick;
    logic             start_ok;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;

    assign mode      = mode_e'(mode_i);
    assign tick      = en_i && (pre_q == div_i);
    assign start_ok  = (mode == MODE_ONESHOT) && start_i && (os_q != OS_RUN);
    assign count_inc = count_q + WIDTH'(1);
    assign count_dec = count_q - WIDTH'(1);

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        tc_d    = 1'b0;
        dir_d   = dir_q;
        busy_d  = busy_q;
        os_d    = os_q;

        if (en_i) begin
            pre_d = tick ? '0 : pre_q + DIV_W'(1);
        end

        // Fixed-direction modes pin dir immediately; count follows at the next tick.
        if (mode == MODE_UP) begin
            dir_d = 1'b1;
        end else if (mode == MODE_DOWN) begin
            dir_d = 1'b0;
        end

        if (mode != MODE_ONESHOT) begin
            os_d   = OS_IDLE;
            busy_d = 1'b0;
        end

        if (load_i) begin
            count_d = load_val_i;
            pre_d   = '0;
        end else if (start_ok) begin
            count_d = '0;
            pre_d   = '0;
            busy_d  = 1'b1;
            os_d    = OS_RUN;
        end else if (tick) begin
            case (mode)
                MODE_UP: begin
                    if (count_q >= limit_i) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_inc;
                    end
                end
                MODE_DOWN: begin
                    if (count_q == '0) begin
                        count_d = limit_i;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_dec;
                    end
                end
                MODE_BOUNCE: begin
                    if ((limit_i == '0) && (count_q == '0)) begin
                        tc_d = 1'b1;
                    end else if (dir_q && (count_q >= limit_i)) begin
                        dir_d   = 1'b0;
                        count_d = count_dec;
                        tc_d    = 1'b1;
                    end else if (!dir_q && (count_q == '0)) begin
                        dir_d   = 1'b1;
                        count_d = count_inc;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = dir_q ? count_inc : count_dec;
                    end
                end
                MODE_ONESHOT: begin
                    if (os_q == OS_RUN) begin
                        count_d = count_inc;
                        if (count_inc >= limit_i) begin
                            tc_d   = 1'b1;
                            busy_d = 1'b0;
                            os_d   = OS_DONE;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge gclk_i) begin
        if (!reset_i) begin
            pre_q   <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
            dir_q   <= 1'b1;
            busy_q  <= 1'b0;
            os_q    <= OS_IDLE;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            os_q    <= os_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign busy_o  = busy_q;
    assign dir_o   = dir_q;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: an integer-arithmetic reference model compared
// every cycle, plus hand-computed literal checkpoints from directed scenarios.
module tb_prog_counter;

    logic       gclk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] div;
    logic [3:0] limit;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       dir;

    int n_cmp  = 0;
    int n_fail = 0;

    prog_counter #(.WIDTH(4), .DIV_W(8)) dut (
        .gclk_i     (gclk),
        .reset_i    (reset),
        .en_i       (en),
        .mode_i     (mode),
        .div_i      (div),
        .limit_i    (limit),
        .load_i     (load),
        .load_val_i (load_val),
        .start_i    (start),
        .count_o    (count),
        .tc_o       (tc),
        .busy_o     (busy),
        .dir_o      (dir)
    );

    always #5 gclk = ~gclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: plain integers, count modulo 16; one-shot phase 0=idle 1=run 2=done.
    int m_count = 0, m_pre = 0, m_tc = 0, m_dir = 1, m_busy = 0, m_phase = 0;
    bit m_valid = 0;

    always @(posedge gclk) begin
        int  n_count, n_pre, n_tc, n_dir, n_busy, n_phase, lim;
        bit  is_tick;
        if (!reset) begin
            m_count = 0; m_pre = 0; m_tc = 0; m_dir = 1; m_busy = 0; m_phase = 0;
        end else begin
            lim     = int'(limit);
            is_tick = en && (m_pre == int'(div));
            n_count = m_count;
            n_pre   = en ? (is_tick ? 0 : (m_pre + 1) % 256) : m_pre;
            n_tc    = 0;
            n_dir   = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 0 : m_dir;
            n_busy  = m_busy;
            n_phase = m_phase;
            if (mode != 2'd3) begin
                n_phase = 0;
                n_busy  = 0;
            end
            if (load) begin
                n_count = int'(load_val);
                n_pre   = 0;
            end else if (mode == 2'd3 && start && m_phase != 1) begin
                n_count = 0; n_pre = 0; n_busy = 1; n_phase = 1;
            end else if (is_tick) begin
                if (mode == 2'd0) begin
                    if (m_count >= lim) begin n_count = 0; n_tc = 1; end
                    else n_count = (m_count + 1) % 16;
                end else if (mode == 2'd1) begin
                    if (m_count == 0) begin n_count = lim; n_tc = 1; end
                    else n_count = m_count - 1;
                end else if (mode == 2'd2) begin
                    if (lim == 0 && m_count == 0) n_tc = 1;
                    else if (m_dir == 1 && m_count >= lim) begin n_dir = 0; n_count = m_count - 1; n_tc = 1; end
                    else if (m_dir == 0 && m_count == 0) begin n_dir = 1; n_count = 1; n_tc = 1; end
                    else n_count = (m_dir == 1) ? (m_count + 1) % 16 : m_count - 1;
                end else if (m_phase == 1) begin
                    n_count = (m_count + 1) % 16;
                    if (n_count >= lim) begin n_tc = 1; n_busy = 0; n_phase = 2; end
                end
            end
            m_count = n_count; m_pre = n_pre; m_tc = n_tc;
            m_dir = n_dir; m_busy = n_busy; m_phase = n_phase;
        end
        m_valid = 1;
    end

    always @(negedge gclk) begin
        if (m_valid) begin
            check("model.count", 32'(count), 32'(m_count));
            check("model.tc",    32'(tc),    32'(m_tc));
            check("model.busy",  32'(busy),  32'(m_busy));
            check("model.dir",   32'(dir),   32'(m_dir));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge gclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; en = 1'b1; mode = 2'd0; div = 8'd0; limit = 4'd15;
        load = 1'b0; load_val = 4'd0; start = 1'b0;

        // Reset state, then free-running up-wrap to 15
        step(3);
        check("rst.count", 32'(count), 32'd0);
        check("rst.tc",    32'(tc),    32'd0);
        check("rst.busy",  32'(busy),  32'd0);
        check("rst.dir",   32'(dir),   32'd1);
        reset = 1'b1;
        step(15);
        check("up.count15", 32'(count), 32'd15);
        check("up.tc15",    32'(tc),    32'd0);
        step(1);
        check("up.wrap",    32'(count), 32'd0);
        check("up.wrap_tc", 32'(tc),    32'd1);
        step(1);
        check("up.after",   32'(count), 32'd1);

        // Prescaled up-wrap with enable freeze
        div = 8'd2; limit = 4'd3; load = 1'b1; load_val = 4'd0;
        step(1);
        load = 1'b0;
        step(3);
        check("div.first", 32'(count), 32'd1);
        step(6);
        check("div.three", 32'(count), 32'd3);
        step(1);
        en = 1'b0;
        step(5);
        check("div.frozen", 32'(count), 32'd3);
        en = 1'b1;
        step(2);
        check("div.resume",    32'(count), 32'd0);
        check("div.resume_tc", 32'(tc),    32'd1);

        // Down-wrap
        mode = 2'd1; div = 8'd0; limit = 4'd5; load = 1'b1; load_val = 4'd0;
        step(1);
        load = 1'b0;
        check("dn.dir", 32'(dir), 32'd0);
        step(1);
        check("dn.wrap",    32'(count), 32'd5);
        check("dn.wrap_tc", 32'(tc),    32'd1);
        step(5);
        check("dn.zero", 32'(count), 32'd0);
        step(1);
        check("dn.again", 32'(count), 32'd5);

        // Bounce, then limit 0
        mode = 2'd0; limit = 4'd3; load = 1'b1; load_val = 4'd0;
        step(1);
        load = 1'b0; mode = 2'd2;
        step(4);
        check("bn.top",    32'(count), 32'd2);
        check("bn.top_tc", 32'(tc),    32'd1);
        check("bn.top_dir", 32'(dir),  32'd0);
        step(3);
        check("bn.bot",    32'(count), 32'd1);
        check("bn.bot_tc", 32'(tc),    32'd1);
        limit = 4'd0;
        step(4);
        check("bn.lim0",    32'(count), 32'd0);
        check("bn.lim0_tc", 32'(tc),    32'd1);

        // One-shot
        mode = 2'd3; limit = 4'd4; start = 1'b1;
        step(1);
        start = 1'b0;
        check("os.start_busy", 32'(busy), 32'd1);
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("os.ignored", 32'(count), 32'd3);
        step(1);
        check("os.done",    32'(count), 32'd4);
        check("os.done_tc", 32'(tc),    32'd1);
        check("os.done_busy", 32'(busy), 32'd0);
        step(3);
        check("os.hold", 32'(count), 32'd4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        check("os.restart", 32'(count), 32'd2);

        // Load with en low, then reset mid-run
        en = 1'b0; load = 1'b1; load_val = 4'd9;
        step(1);
        load = 1'b0; en = 1'b1;
        check("ld.val", 32'(count), 32'd9);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        check("rst2.count", 32'(count), 32'd0);
        check("rst2.busy",  32'(busy),  32'd0);
        step(2);
        check("rst2.idle", 32'(count), 32'd0);

        // Limit lowered below count in up-wrap; leaving one-shot mid-run
        mode = 2'd0; limit = 4'd15; load = 1'b1; load_val = 4'd10;
        step(1);
        load = 1'b0; limit = 4'd5;
        step(1);
        check("low.wrap", 32'(count), 32'd0);
        mode = 2'd3; limit = 4'd9; start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        mode = 2'd0;
        step(1);
        check("leave.busy", 32'(busy), 32'd0);
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
